// File: rtl/router_pkg.sv
// Shared definitions for the router packet source.
// Holds the FSM state type, the reserved (invalid) destination address,
// the default payload length limit and a helper that builds a header byte.
package router_pkg;

  // The state names the byte currently presented on d_out.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2,
    PAR  = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_INVALID    = 2'b11;
  localparam int         MAX_LEN_DEFAULT = 63;

  // Header byte: payload length in the upper six bits, destination below.
  function automatic logic [7:0] make_header(input logic [5:0] len, input logic [1:0] addr);
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_pkt_src_if.sv
// Bus between the packet source, its payload FIFO and the router.
//   start/addr/payload_len/inj_err : packet request from the controller
//   pl_data/pl_rd                  : show-ahead payload source and pop strobe
//   busy                           : router stall
//   pkt_vld/d_out                  : byte stream to the router
//   tx_active/done/err             : status back to the controller
// master : the packet source itself
// slave  : everything around it (controller, FIFO, router)
interface router_pkt_src_if;
  logic       start;
  logic [1:0] addr;
  logic [5:0] payload_len;
  logic       inj_err;
  logic [7:0] pl_data;
  logic       pl_rd;
  logic       busy;
  logic       pkt_vld;
  logic [7:0] d_out;
  logic       tx_active;
  logic       done;
  logic       err;

  modport master (
    input  start, addr, payload_len, inj_err, pl_data, busy,
    output pl_rd, pkt_vld, d_out, tx_active, done, err
  );

  modport slave (
    output start, addr, payload_len, inj_err, pl_data, busy,
    input  pl_rd, pkt_vld, d_out, tx_active, done, err
  );
endinterface

// File: rtl/router_parity_acc.sv
// Running XOR of a packet's bytes.
//   clk, rstn : clock and asynchronous active-low reset
//   load      : start a new accumulation with din (the header)
//   xor_en    : fold din (a payload byte) into the running value
//   clear     : return the accumulator to zero once the packet is finished
//   din       : byte to load or fold in
//   parity    : current accumulated value
module router_parity_acc (
  input  logic       clk,
  input  logic       rstn,
  input  logic       load,
  input  logic       xor_en,
  input  logic       clear,
  input  logic [7:0] din,
  output logic [7:0] parity
);

  // Clear wins over load, load over xor; the controller never asserts
  // two of them together, but the priority keeps the behaviour defined.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      parity <= 8'h00;
    end else if (clear) begin
      parity <= 8'h00;
    end else if (load) begin
      parity <= din;
    end else if (xor_en) begin
      parity <= parity ^ din;
    end
  end

endmodule

// File: rtl/router_pkt_src.sv
// Packet source feeding one router input.
// On an accepted start it emits a header byte {payload_len, addr}, then
// payload_len bytes popped from a show-ahead source, then a parity byte
// (XOR of header and payload, bit 0 optionally inverted), then pulses done.
// Invalid requests (addr 3, length 0 or above MAX_LEN) pulse err instead.
//   clk, rstn : clock and asynchronous active-low reset
//   bus       : router_pkt_src_if master modport (request, payload, router
//               byte stream and status)
module router_pkt_src
  import router_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEFAULT
) (
  input  logic              clk,
  input  logic              rstn,
  router_pkt_src_if.master  bus
);

  localparam logic [6:0] MAX_LEN_W = 7'(MAX_LEN);

  state_t     state;
  logic [5:0] cnt;
  logic [5:0] len_q;
  logic       inj_q;
  logic [7:0] d_out_q;
  logic       pkt_vld_q;
  logic       done_q;
  logic       err_q;

  logic [7:0] header;
  logic       req_valid;
  logic       accept;
  logic       pop;
  logic       par_clear;
  logic [7:0] parity;
  logic [7:0] acc_din;

  assign header    = make_header(bus.payload_len, bus.addr);
  assign req_valid = (bus.addr != ADDR_INVALID) &&
                     (bus.payload_len != 6'd0) &&
                     ({1'b0, bus.payload_len} <= MAX_LEN_W);

  // Nothing in the block moves while the router stalls, including a
  // request arriving in IDLE.
  assign accept    = !bus.busy && (state == IDLE) && bus.start && req_valid;

  // The source is show-ahead, so the byte is consumed on the same edge
  // that pl_rd is high; the header cycle always pops since len >= 1.
  assign pop       = !bus.busy && ((state == HDR) || ((state == PAY) && (cnt < len_q)));
  assign par_clear = !bus.busy && (state == PAR);
  assign acc_din   = accept ? header : bus.pl_data;

  router_parity_acc u_parity (
    .clk    (clk),
    .rstn   (rstn),
    .load   (accept),
    .xor_en (pop),
    .clear  (par_clear),
    .din    (acc_din),
    .parity (parity)
  );

  // Packet sequencer. done and err are single-cycle pulses so they default
  // low every edge; all other state only changes on a non-stalled edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= 6'd0;
      len_q     <= 6'd0;
      inj_q     <= 1'b0;
      d_out_q   <= 8'h00;
      pkt_vld_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (!bus.busy) begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              if (req_valid) begin
                d_out_q   <= header;
                pkt_vld_q <= 1'b1;
                cnt       <= 6'd0;
                len_q     <= bus.payload_len;
                inj_q     <= bus.inj_err;
                state     <= HDR;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          HDR: begin
            d_out_q <= bus.pl_data;
            cnt     <= cnt + 6'd1;
            state   <= PAY;
          end
          PAY: begin
            if (cnt < len_q) begin
              d_out_q <= bus.pl_data;
              cnt     <= cnt + 6'd1;
            end else begin
              d_out_q   <= parity ^ {7'b0, inj_q};
              pkt_vld_q <= 1'b0;
              state     <= PAR;
            end
          end
          PAR: begin
            d_out_q <= 8'h00;
            done_q  <= 1'b1;
            cnt     <= 6'd0;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.pl_rd     = pop;
  assign bus.d_out     = d_out_q;
  assign bus.pkt_vld   = pkt_vld_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.tx_active = (state != IDLE);

endmodule
